// File: rtl/mano_io_terminal.sv
`default_nettype none
// ============================================================================
// mano_io_terminal : device-side INPR/FGI and OUTR/FGO flag handshake with a
//                    keyboard FIFO and a printer busy-time countdown.
// Revision 1.0
// ============================================================================
module mano_io_terminal #(
  parameter int KEY_DEPTH    = 4,
  parameter int PRINT_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       out_ld,
  input  logic [7:0] out_data,
  input  logic       inp_rd,
  input  logic       ien,
  output logic [7:0] INPR,
  output logic       FGI,
  output logic       FGO,
  output logic       irq,
  output logic       out_err,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       key_ready,
  output logic       prn_valid,
  output logic [7:0] prn_data,
  input  logic       prn_ready
);

  localparam int AW = $clog2(KEY_DEPTH);
  localparam int CW = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(PRINT_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(KEY_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    BUSY   = 2'd2
  } out_state_t;

  logic [7:0]    key_mem_q [KEY_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    inpr_q;
  logic          fgi_q;
  logic          key_ready_q;

  out_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    outr_q;
  logic          fgo_q;
  logic          prn_valid_q;
  logic          out_err_q;

  logic push, pop;

  // key_ready is registered, so a full FIFO never accepts a push even when
  // a pop happens on the same edge.
  assign push = key_valid & key_ready_q;
  assign pop  = ~fgi_q & (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) key_mem_q[wr_ptr_q] <= key_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_ready_q <= 1'b1;
      inpr_q      <= 8'h00;
      fgi_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      key_ready_q <= (count_d != DEPTH_CNT);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        inpr_q   <= key_mem_q[rd_ptr_q];
        fgi_q    <= 1'b1;
      end else if (inp_rd && fgi_q) begin
        fgi_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      outr_q      <= 8'h00;
      fgo_q       <= 1'b1;
      prn_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      // A write arriving while not idle is an overrun: OUTR keeps its value.
      if (out_ld && state_q != IDLE) out_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (out_ld) begin
            outr_q      <= out_data;
            state_q     <= LOADED;
            fgo_q       <= 1'b0;
            prn_valid_q <= 1'b1;
          end
        end
        LOADED: begin
          if (prn_ready) begin
            state_q     <= BUSY;
            cnt_q       <= CNT_LOAD;
            prn_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            fgo_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          fgo_q       <= 1'b1;
          prn_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign INPR      = inpr_q;
  assign FGI       = fgi_q;
  assign FGO       = fgo_q;
  assign irq       = ien & (fgi_q | fgo_q);
  assign out_err   = out_err_q;
  assign key_ready = key_ready_q;
  assign prn_valid = prn_valid_q;
  assign prn_data  = outr_q;

endmodule
`default_nettype wire

// File: tb/tb_mano_io_terminal.sv
`default_nettype none
// ============================================================================
// tb_mano_io_terminal : directed test-plan scenarios plus random traffic,
//                       checked every cycle against a queue-based model.
// Revision 1.0
// ============================================================================
module tb_mano_io_terminal;

  localparam int KD = 4;
  localparam int PC = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       out_ld = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       inp_rd = 1'b0;
  logic       ien = 1'b0;
  logic [7:0] INPR;
  logic       FGI, FGO, irq, out_err;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_ready;
  logic       prn_valid;
  logic [7:0] prn_data;
  logic       prn_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mano_io_terminal #(.KEY_DEPTH(KD), .PRINT_CYCLES(PC)) dut (
    .CLK(CLK), .RST(RST), .out_ld(out_ld), .out_data(out_data),
    .inp_rd(inp_rd), .ien(ien), .INPR(INPR), .FGI(FGI), .FGO(FGO),
    .irq(irq), .out_err(out_err), .key_valid(key_valid), .key_data(key_data),
    .key_ready(key_ready), .prn_valid(prn_valid), .prn_data(prn_data),
    .prn_ready(prn_ready)
  );

  always #5 CLK = ~CLK;

  // Reference model: keystroke queue, flags, and the edge number at which the
  // printer becomes ready again.
  logic [7:0] kq[$];
  logic [7:0] m_inpr, m_outr;
  bit         m_fgi, m_loaded, m_err;
  int         m_ready_at, n_edge;

  function automatic bit m_fgo();
    return !m_loaded && (n_edge >= m_ready_at);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_loaded, idle_now, do_pop, do_push;
    if (RST) begin
      kq.delete();
      m_inpr = 8'h00; m_outr = 8'h00;
      m_fgi = 0; m_loaded = 0; m_err = 0; m_ready_at = 0;
    end else begin
      was_loaded = m_loaded;
      idle_now   = m_fgo();
      do_pop     = !m_fgi && kq.size() > 0;
      do_push    = key_valid && kq.size() < KD;
      if (do_pop) begin
        m_inpr = kq.pop_front();
        m_fgi  = 1;
      end else if (inp_rd && m_fgi) begin
        m_fgi = 0;
      end
      if (do_push) kq.push_back(key_data);
      if (out_ld) begin
        if (idle_now) begin
          m_outr = out_data; m_loaded = 1;
        end else begin
          m_err = 1;
        end
      end
      if (was_loaded && prn_ready) begin
        m_loaded   = 0;
        m_ready_at = n_edge + 1 + PC;
      end
    end
    n_edge++;
  endtask

  task automatic compare_all();
    check_val("INPR", INPR, m_inpr);
    check_val("FGI", FGI, m_fgi);
    check_val("FGO", FGO, m_fgo());
    check_val("irq", irq, ien & (m_fgi | m_fgo()));
    check_val("out_err", out_err, m_err);
    check_val("key_ready", key_ready, kq.size() < KD);
    check_val("prn_valid", prn_valid, m_loaded);
    check_val("prn_data", prn_data, m_outr);
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    key_valid = 0; inp_rd = 0; out_ld = 0;
  endtask

  initial begin
    int k;
    n_edge = 0; m_ready_at = 0;
    kq.delete();
    m_inpr = 0; m_outr = 0; m_fgi = 0; m_loaded = 0; m_err = 0;

    // Reset then idle
    RST = 1; ien = 1;
    cycle(); cycle();
    RST = 0;
    check_val("rst_FGI", FGI, 0);
    check_val("rst_FGO", FGO, 1);
    check_val("rst_INPR", INPR, 8'h00);
    check_val("rst_key_ready", key_ready, 1);
    check_val("rst_prn_valid", prn_valid, 0);
    check_val("rst_out_err", out_err, 0);
    check_val("rst_irq", irq, 1);

    // Single keystroke
    key_valid = 1; key_data = 8'h41;
    cycle();
    key_valid = 0;
    cycle();
    check_val("key_FGI", FGI, 1);
    check_val("key_INPR", INPR, 8'h41);
    inp_rd = 1;
    cycle();
    inp_rd = 0;
    check_val("rd_FGI", FGI, 0);
    check_val("rd_INPR", INPR, 8'h41);
    cycle();

    // FIFO fill / backpressure
    for (int i = 0; i < 5; i++) begin
      key_valid = 1; key_data = 8'h30 + 8'(i);
      cycle();
    end
    check_val("fill_INPR", INPR, 8'h30);
    check_val("fill_key_ready", key_ready, 0);
    key_data = 8'h35;
    cycle(); cycle();
    check_val("held_key_ready", key_ready, 0);
    key_valid = 0;
    for (int i = 0; i < 5; i++) begin
      inp_rd = 1;
      cycle();
      inp_rd = 0;
      cycle();
      if (i < 4) check_val("fifo_order", INPR, 8'h31 + 8'(i));
    end
    check_val("drain_FGI", FGI, 0);

    // Print flow
    out_ld = 1; out_data = 8'h5A; prn_ready = 0;
    cycle();
    out_ld = 0;
    for (int i = 0; i < 10; i++) begin
      check_val("hold_prn_valid", prn_valid, 1);
      check_val("hold_prn_data", prn_data, 8'h5A);
      check_val("hold_FGO", FGO, 0);
      cycle();
    end
    prn_ready = 1;
    cycle();
    prn_ready = 0;
    check_val("hs_prn_valid", prn_valid, 0);
    k = 0;
    while (FGO !== 1'b1 && k < 40) begin
      cycle();
      k++;
    end
    check_val("busy_cycles", k, PC);

    // Overrun
    out_ld = 1; out_data = 8'h11;
    cycle();
    out_ld = 0; prn_ready = 1;
    cycle();
    prn_ready = 0;
    cycle();
    out_ld = 1; out_data = 8'h22;
    cycle();
    out_ld = 0;
    check_val("ovr_prn_data", prn_data, 8'h11);
    check_val("ovr_err", out_err, 1);
    for (int i = 0; i < PC + 2; i++) cycle();
    check_val("err_sticky", out_err, 1);

    // Reset mid-operation
    out_ld = 1; out_data = 8'h77;
    cycle();
    out_ld = 0; prn_ready = 1;
    cycle();
    prn_ready = 0;
    for (int i = 0; i < 3; i++) begin
      key_valid = 1; key_data = 8'hA0 + 8'(i);
      cycle();
    end
    key_valid = 0;
    check_val("mid_FGI", FGI, 1);
    RST = 1;
    cycle();
    RST = 0;
    check_val("mid_FGO", FGO, 1);
    check_val("mid_FGI0", FGI, 0);
    check_val("mid_key_ready", key_ready, 1);
    check_val("mid_err", out_err, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("mid_noprn", prn_valid, 0);
      check_val("mid_noFGI", FGI, 0);
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      key_valid = 1'($urandom % 2);
      key_data  = 8'($urandom);
      inp_rd    = ($urandom % 3) == 0;
      out_ld    = ($urandom % 6) == 0;
      out_data  = 8'($urandom);
      prn_ready = 1'($urandom % 2);
      ien       = 1'($urandom % 2);
      RST       = ($urandom % 250) == 0;
      cycle();
    end
    idle_inputs();
    RST = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mano_io_terminal.md
Name: mano_io_terminal

Overview:
- Device-side end of the basic computer's I/O flag handshake; the CPU core is the initiator through its INP/OUT instructions.
- Owns INPR/FGI (keyboard → CPU) and OUTR/FGO (CPU → printer).
- Buffers keystrokes in a small FIFO and models printer busy time with a countdown.
- Sits beside the accumulator/bus datapath and produces the I/O interrupt request.

Parameters:
- KEY_DEPTH, 4: keyboard FIFO entries; power of two, ≥2.
- PRINT_CYCLES, 8: printer busy cycles after each accepted character; ≥1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- out_ld  input  1  CPU OUT strobe: OUTR←out_data, FGO←0.
- out_data  input  8  AC(7:0) from the CPU.
- inp_rd  input  1  CPU INP strobe: CPU takes INPR, FGI←0.
- ien  input  1  CPU interrupt enable flip-flop.
- INPR  output  8  input register, read by the CPU.
- FGI  output  1  input flag: 1 = INPR holds an unread character.
- FGO  output  1  output flag: 1 = terminal ready for a new character.
- irq  output  1  ien & (FGI | FGO), combinational from registers.
- out_err  output  1  sticky; set when out_ld arrives while FGO=0.
- key_valid  input  1  keyboard offers key_data.
- key_data  input  8  keystroke code.
- key_ready  output  1  FIFO not full.
- prn_valid  output  1  printer character available.
- prn_data  output  8  equals OUTR.
- prn_ready  input  1  printer accepts prn_data.

Behaviour:
- Reset (synchronous, dominates every other input):
  - INPR=0, FGI=0, OUTR=0, FGO=1, out_err=0, prn_valid=0.
  - FIFO empty, so key_ready=1; output FSM=IDLE; busy counter=0.
  - Any in-flight character or queued keystroke is discarded.
- Keyboard FIFO:
  - Push on key_valid & key_ready.
  - key_ready = ~full. A keystroke offered while full is not accepted; the keyboard holds it.
  - Pointers wrap modulo KEY_DEPTH; occupancy counter ranges 0..KEY_DEPTH.
  - Push and pop in the same cycle: both occur, occupancy unchanged. This is legal when full (the pop frees the slot) only if key_ready was already 1, so with registered key_ready no push occurs while full.
- INPR load: when FGI=0 and the FIFO is non-empty, on the next edge INPR←head, pop, FGI←1.
- Keyboard latency: a key accepted at edge k into an empty FIFO with FGI=0 gives FGI=1 and INPR valid after edge k+1.
- inp_rd:
  - With FGI=1: FGI←0 on the next edge; INPR holds its value.
  - The next refill can happen one edge later, so there is at least one cycle with FGI=0 between characters.
  - With FGI=0: ignored.
- Output FSM states: IDLE (FGO=1, prn_valid=0), LOADED (FGO=0, prn_valid=1), BUSY (FGO=0, prn_valid=0).
- Output FSM transitions:
  - IDLE + out_ld: OUTR←out_data, go to LOADED.
  - LOADED + prn_ready: go to BUSY, cnt←PRINT_CYCLES-1.
  - BUSY: cnt decrements each cycle; at cnt==0 go to IDLE with FGO←1 on the same edge.
- Output flow example: out_ld at edge k, prn_ready held high → handshake at edge k+1 → FGO=1 after edge k+1+PRINT_CYCLES.
- out_ld while FGO=0 (LOADED or BUSY): OUTR unchanged, character dropped, out_err←1 (sticky until RST).
- prn_data always equals OUTR. prn_valid stays asserted in LOADED until prn_ready; data is stable while valid.
- The input and output paths are fully independent. out_ld and inp_rd may be asserted in the same cycle and both take effect.

Test Plan:
- Reset then idle: RST for 2 cycles → FGI=0, FGO=1, INPR=0x00, key_ready=1, prn_valid=0, out_err=0; with ien=1, irq=1 (FGO).
- Single keystroke: key_valid for 1 cycle with key_data=0x41 → after 2 edges FGI=1, INPR=0x41. inp_rd for 1 cycle → FGI=0 next cycle, INPR stays 0x41.
- FIFO fill/backpressure:
  - Stimulus: push 0x30..0x34 back-to-back with no inp_rd.
  - 0x30 moves into INPR; 4 more fill the FIFO; key_ready drops. Later keys are held, not lost.
  - Then inp_rd five times → INPR reads 0x31, 0x32, 0x33, 0x34 in order. FGI=0 after the last read.
- Print flow (PRINT_CYCLES=8):
  - out_ld with out_data=0x5A while prn_ready=0 → FGO=0, prn_valid=1, prn_data=0x5A, held for 10 cycles.
  - Then prn_ready=1 → prn_valid=0, and FGO=1 exactly 8 cycles after the handshake edge.
- Overrun: out_ld 0x11 then out_ld 0x22 during BUSY → OUTR stays 0x11, out_err=1; out_err clears only on RST.
- Reset mid-operation: RST during BUSY with 2 keys queued and FGI=1 → next cycle FGO=1, FGI=0, FIFO empty, state IDLE, no further prn_valid.
